// File: rtl/fetch_stream_source.sv
// rtl/fetch_stream_source.sv - credit-gated fetch response buffer with a valid/ready output
// Optional zero-latency response bypass when FETCH_STREAM_BYPASS_EN is defined.
module fetch_stream_source #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  output logic req_valid,
  input  logic req_ready,
  input  logic resp_valid,
  input  T     resp_data,
  output logic valid_out,
  input  logic ready_out,
  output T     data_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic          w_fire;
  logic          w_resp_ok;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic          w_bypass_pop;
  logic          w_write;
  logic [CW:0]   w_credit_used;
  T              w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // In-flight requests hold a credit until their response returns, dropped or not.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
  assign req_valid     = !reset && !flush && (w_credit_used < DEPTH_W);
  assign w_fire        = req_valid && req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_resp_ok = resp_valid && (r_outstanding != '0);
  assign w_drop    = w_resp_ok && (r_drop_cnt != '0);
  assign w_push    = w_resp_ok && (r_drop_cnt == '0) && !flush;
  assign w_pop     = ready_out && (r_count != '0) && !flush;
  assign w_head    = r_mem[r_rd_ptr];

`ifdef FETCH_STREAM_BYPASS_EN
  assign w_bypass  = w_push && (r_count == '0);
  assign valid_out = !reset && ((r_count != '0) || w_bypass);
  assign data_out  = reset ? '0 : ((r_count != '0) ? w_head : resp_data);
`else
  assign w_bypass  = 1'b0;
  assign valid_out = !reset && (r_count != '0);
  assign data_out  = reset ? '0 : w_head;
`endif

  // A bypassed response consumed in the same cycle never occupies an entry.
  assign w_bypass_pop = w_bypass && ready_out;
  assign w_write      = w_push && !w_bypass_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_resp_ok);
      if (flush) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_drop_cnt <= r_outstanding - CW'(w_resp_ok);
      end else begin
        if (w_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
        if (w_write) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + CW'(w_write) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= resp_data;
  end

endmodule

// File: tb/tb_fetch_stream_source.sv
// tb/tb_fetch_stream_source.sv - directed and randomized checks against a queue-level model
// Define FETCH_STREAM_BYPASS_EN to exercise the zero-latency path.
module tb_fetch_stream_source;
  localparam int DEPTH = 4;
`ifdef FETCH_STREAM_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        flush      = 1'b0;
  logic        req_ready  = 1'b0;
  logic        resp_valid = 1'b0;
  logic        ready_out  = 1'b0;
  logic [31:0] resp_data  = '0;
  logic        req_valid;
  logic        valid_out;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  fetch_stream_source #(.T(logic [31:0]), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory model: in-order responses, each no earlier than its due cycle.
  typedef struct {
    logic [31:0] data;
    int          due;
  } mreq_t;
  mreq_t       mem_q[$];
  mreq_t       mem_tmp;
  logic [31:0] data_list[$];
  int          fire_budget = 0;
  int          resp_budget = -1;
  int          lat_min     = 1;
  int          lat_max     = 1;
  int          req_pct     = 100;
  int          fire_cnt    = 0;
  logic [31:0] pop_data[$];
  int          pop_cyc[$];
  int          resp_cyc[$];

  // Reference model: buffered payloads in order, in-flight count, pending drops.
  logic [31:0] m_q[$];
  int          m_out  = 0;
  int          m_drop = 0;
  logic        e_rv, e_vo, e_byp, m_resp_ok, m_fire, m_taken;
  logic [31:0] e_do;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pops(input int n, input int limit, input string name);
    int k = 0;
    while (pop_data.size() < n && k < limit) begin
      step(1);
      k++;
    end
    chk(name, 32'(pop_data.size() >= n), 32'd1);
  endtask

  task automatic clear_logs();
    pop_data.delete();
    pop_cyc.delete();
    resp_cyc.delete();
    data_list.delete();
  endtask

  // Memory-side driver: inputs change 1 time unit after the clock edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    resp_valid = 1'b0;
    resp_data  = $urandom;
    if (mem_q.size() != 0 && resp_budget != 0) begin
      if (mem_q[0].due <= cyc) begin
        resp_valid = 1'b1;
        resp_data  = mem_q[0].data;
      end
    end
    req_ready = (fire_budget != 0) && (int'($urandom_range(99, 0)) < req_pct);
  end

  // Memory bookkeeping and transfer logs, taken mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      mem_q.delete();
    end else begin
      if (valid_out && ready_out && !flush) begin
        pop_data.push_back(data_out);
        pop_cyc.push_back(cyc);
      end
      if (resp_valid && mem_q.size() != 0) begin
        mem_tmp = mem_q.pop_front();
        resp_cyc.push_back(cyc);
        if (resp_budget > 0) resp_budget--;
      end
      if (req_valid && req_ready) begin
        if (data_list.size() != 0) mem_tmp.data = data_list.pop_front();
        else mem_tmp.data = $urandom;
        mem_tmp.due = cyc + int'($urandom_range(lat_max, lat_min));
        mem_q.push_back(mem_tmp);
        fire_cnt++;
        if (fire_budget > 0) fire_budget--;
      end
    end
  end

  // Compare process: expected outputs from the model, then advance the model.
  always @(negedge clk) begin
    m_resp_ok = resp_valid && (m_out > 0);
    e_byp     = 1'b0;
`ifdef FETCH_STREAM_BYPASS_EN
    e_byp = !reset && !flush && (m_q.size() == 0) && (m_drop == 0) && m_resp_ok;
`endif
    e_rv = !reset && !flush && ((m_q.size() + m_out) < DEPTH);
    e_vo = !reset && ((m_q.size() != 0) || e_byp);
    e_do = reset ? 32'd0 : ((m_q.size() != 0) ? m_q[0] : resp_data);
    chk("req_valid", 32'(req_valid), 32'(e_rv));
    chk("valid_out", 32'(valid_out), 32'(e_vo));
    if (reset || e_vo) chk("data_out", data_out, e_do);

    m_fire  = e_rv && req_ready;
    m_taken = 1'b0;
    if (reset) begin
      m_q.delete();
      m_out  = 0;
      m_drop = 0;
    end else if (flush) begin
      m_q.delete();
      m_drop = m_out - int'(m_resp_ok);
      m_out  = m_out - int'(m_resp_ok);
    end else begin
      if (e_vo && ready_out) begin
        if (m_q.size() != 0) e_do = m_q.pop_front();
        else m_taken = 1'b1;
      end
      if (m_resp_ok) begin
        if (m_drop > 0) m_drop--;
        else if (!m_taken) m_q.push_back(resp_data);
      end
      m_out = m_out + int'(m_fire) - int'(m_resp_ok);
    end
  end

  initial begin
    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", data_out, 32'd0);

    // Streaming: three responses, one cycle after each fire
    step(1);
    clear_logs();
    reset     = 1'b0;
    ready_out = 1'b1;
    data_list.push_back(32'h10);
    data_list.push_back(32'h20);
    data_list.push_back(32'h30);
    fire_budget = 3;
    wait_pops(3, 40, "t1_timeout");
    if (pop_data.size() >= 3 && resp_cyc.size() >= 3) begin
      chk("t1_data0", pop_data[0], 32'h10);
      chk("t1_data1", pop_data[1], 32'h20);
      chk("t1_data2", pop_data[2], 32'h30);
      chk("t1_latency", 32'(pop_cyc[0] - resp_cyc[0]), 32'(LAT));
      chk("t1_no_bubble", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);
    end

    // Credit limit with a stalled consumer
    step(2);
    clear_logs();
    fire_cnt  = 0;
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) data_list.push_back(32'h41 + 32'(i));
    fire_budget = -1;
    step(10);
    chk("t2_fire_count", 32'(fire_cnt), 32'd4);
    @(negedge clk);
    chk("t2_rv_full", 32'(req_valid), 32'd0);
    @(posedge clk);
    #2;
    ready_out   = 1'b1;
    fire_budget = 0;
    @(negedge clk);
    chk("t2_rv_first_pop", 32'(req_valid), 32'd0);
    @(negedge clk);
    chk("t2_rv_after_pop", 32'(req_valid), 32'd1);
    step(1);
    wait_pops(4, 20, "t2_timeout");
    if (pop_data.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", pop_data[i], 32'h41 + 32'(i));
    end

    // Flush with one buffered entry and two responses in flight
    step(2);
    clear_logs();
    ready_out = 1'b0;
    data_list.push_back(32'hAA);
    data_list.push_back(32'h01);
    data_list.push_back(32'h02);
    data_list.push_back(32'hBB);
    resp_budget = 1;
    fire_budget = 3;
    step(8);
    @(negedge clk);
    chk("t3_pre_valid", 32'(valid_out), 32'd1);
    chk("t3_pre_data", data_out, 32'hAA);
    @(posedge clk);
    #2;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t3_post_valid", 32'(valid_out), 32'd0);
    chk("t3_model_drops", 32'(m_drop), 32'd2);
    step(1);
    ready_out   = 1'b1;
    resp_budget = -1;
    fire_budget = 1;
    wait_pops(1, 30, "t3_timeout");
    if (pop_data.size() >= 1) chk("t3_first_after_flush", pop_data[0], 32'hBB);

    // Flush coinciding with a response and a pop, two in flight
    step(2);
    clear_logs();
    ready_out = 1'b0;
    data_list.push_back(32'hC1);
    data_list.push_back(32'hC2);
    data_list.push_back(32'hC3);
    data_list.push_back(32'hD0);
    resp_budget = 1;
    fire_budget = 3;
    step(8);
    resp_budget = 1;
    step(1);
    flush     = 1'b1;
    ready_out = 1'b1;
    @(negedge clk);
    chk("t4_resp_on_flush", 32'(resp_valid), 32'd1);
    @(posedge clk);
    #2;
    flush       = 1'b0;
    resp_budget = -1;
    fire_budget = 1;
    @(negedge clk);
    chk("t4_post_valid", 32'(valid_out), 32'd0);
    chk("t4_model_drops", 32'(m_drop), 32'd1);
    step(1);
    wait_pops(1, 30, "t4_timeout");
    if (pop_data.size() >= 1) chk("t4_first_after_flush", pop_data[0], 32'hD0);

    // Pointer wrap under simultaneous push and pop
    step(2);
    clear_logs();
    ready_out = 1'b0;
    for (int i = 0; i < 13; i++) data_list.push_back(32'h100 + 32'(i));
    fire_budget = 3;
    step(8);
    ready_out   = 1'b1;
    fire_budget = 10;
    wait_pops(13, 80, "t5_timeout");
    if (pop_data.size() >= 13) begin
      for (int i = 0; i < 13; i++) chk("t5_order", pop_data[i], 32'h100 + 32'(i));
    end

    // Reset mid-traffic
    step(2);
    clear_logs();
    ready_out   = 1'b0;
    resp_budget = 2;
    fire_budget = 4;
    step(10);
    chk("t6_model_count", 32'(m_q.size()), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_req_valid", 32'(req_valid), 32'd0);
    chk("t6_rst_valid_out", 32'(valid_out), 32'd0);
    @(posedge clk);
    #2;
    reset       = 1'b0;
    resp_budget = -1;
    @(negedge clk);
    chk("t6_req_valid_after", 32'(req_valid), 32'd1);
    chk("t6_valid_after", 32'(valid_out), 32'd0);

    // Randomized traffic with flushes, occasional resets, variable latency
    step(1);
    clear_logs();
    lat_min     = 1;
    lat_max     = 3;
    req_pct     = 70;
    fire_budget = -1;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      ready_out = (int'($urandom_range(99, 0)) < 60);
      flush     = (int'($urandom_range(99, 0)) < 4);
      reset     = (int'($urandom_range(999, 0)) < 3);
    end
    step(1);
    flush       = 1'b0;
    reset       = 1'b0;
    ready_out   = 1'b1;
    fire_budget = 0;
    step(20);
    @(negedge clk);
    chk("drain_valid_out", 32'(valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
